sr_reg_bank: RTL and testbench

Parametrised, clocked bank of WIDTH set/reset storage bits. It replaces level-sensitive SR latch arrays wherever flag storage must be synchronous and glitch-free. The S=R=1 resolution policy is selectable at elaboration time. Illegal S=R=1 requests are logged per bit and counted, and every change of state raises a one-cycle pulse.

---
 rtl/sr_reg_bank.sv | 103 ++++++++++
 tb/tb_sr_reg_bank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sr_reg_bank.sv
// sr_reg_bank
//   Clocked bank of WIDTH set/reset flag bits, a synchronous replacement for
//   level-sensitive SR latch arrays. The S=R=1 resolution is fixed per instance
//   by MODE. Illegal S=R=1 requests are logged in sticky per-bit flags and
//   counted by a saturating cycle counter. Every state change produces a
//   one-cycle q_chg pulse.
//
// Parameters
//   WIDTH      number of SR bits (1..64)
//   MODE       S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
//   RESET_VAL  value loaded into q on reset and on clr
//   CNT_W      width of the conflict cycle counter (1..32)
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   en            global enable; s and r are ignored when low
//   s, r          per-bit set / reset requests
//   clr           synchronous clear of q to RESET_VAL (overrides en, s, r)
//   conflict_clr  write-one-to-clear for the sticky conflict bits
//   q             stored state
//   q_chg         one-cycle pulse per bit whose q changed at the last edge
//   conflict      sticky per-bit S=R=1 indicator
//   conflict_cnt  saturating count of cycles with at least one new conflict
module sr_reg_bank #(
   parameter int unsigned           WIDTH     = 4,
   parameter int unsigned           MODE      = 0,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0,
   parameter int unsigned           CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clr,
   input  logic [WIDTH-1:0] conflict_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_chg,
   output logic [WIDTH-1:0] conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   // Reject unsupported configurations at elaboration time.
   if (MODE > 3) begin : g_bad_mode
      $error("sr_reg_bank: MODE must be 0..3");
   end
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("sr_reg_bank: WIDTH must be 1..64");
   end
   if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("sr_reg_bank: CNT_W must be 1..32");
   end

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] new_conflict;

   // Next-state decode. clr and a low en both suppress conflict logging, so
   // new_conflict is only non-zero when the s/r decode is actually in effect.
   always_comb begin
      q_next       = q;
      new_conflict = '0;
      if (clr) begin
         q_next = RESET_VAL;
      end else if (en) begin
         new_conflict = s & r;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case ({s[i], r[i]})
               2'b10:   q_next[i] = 1'b1;
               2'b01:   q_next[i] = 1'b0;
               2'b11: begin
                  case (MODE)
                     1:       q_next[i] = 1'b1;
                     2:       q_next[i] = 1'b0;
                     3:       q_next[i] = ~q[i];
                     default: q_next[i] = q[i];
                  endcase
               end
               default: q_next[i] = q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q            <= RESET_VAL;
         q_chg        <= '0;
         conflict     <= '0;
         conflict_cnt <= '0;
      end else begin
         q        <= q_next;
         q_chg    <= q_next ^ q;
         // A new conflict wins over a clear on the same edge.
         conflict <= (conflict & ~conflict_clr) | new_conflict;
         // One count per conflicting cycle, saturating at all-ones.
         if ((|new_conflict) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sr_reg_bank.sv
module tb_sr_reg_bank;

   logic       clk = 1'b0;
   logic       rst_n, en, clr;
   logic [3:0] s, r, conflict_clr;

   logic [3:0] q     [4];
   logic [3:0] q_chg [4];
   logic [3:0] cf    [4];
   logic [7:0] cnt   [4];

   // Separate stimulus for the CNT_W=2 saturation instance.
   logic       rst2_n;
   logic [3:0] s2, r2;
   logic [3:0] q_s, q_chg_s, cf_s;
   logic [1:0] cnt_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 4; gi++) begin : g_m
      sr_reg_bank #(.WIDTH(4), .MODE(gi), .RESET_VAL(4'h5), .CNT_W(8)) u_dut (
         .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr(clr),
         .conflict_clr(conflict_clr), .q(q[gi]), .q_chg(q_chg[gi]),
         .conflict(cf[gi]), .conflict_cnt(cnt[gi])
      );
   end

   sr_reg_bank #(.WIDTH(4), .MODE(0), .RESET_VAL(4'h5), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst2_n), .en(1'b1), .s(s2), .r(r2), .clr(1'b0),
      .conflict_clr(4'h0), .q(q_s), .q_chg(q_chg_s),
      .conflict(cf_s), .conflict_cnt(cnt_s)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_q   [4];
   logic [3:0] exp_chg [4];
   logic [1:0] sat_tab [6];

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0; en = 1'b1; clr = 1'b0;
      s = 4'hF; r = 4'h0; conflict_clr = 4'h0; s2 = 4'h0; r2 = 4'h0;

      // Reset with active requests present
      step(); step();
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("rst_q_m%0d", m), q[m], 4'h5);
         chk($sformatf("rst_chg_m%0d", m), q_chg[m], 4'h0);
         chk($sformatf("rst_cf_m%0d", m), cf[m], 4'h0);
         chk($sformatf("rst_cnt_m%0d", m), cnt[m], 8'd0);
      end
      chk("rst_sat_cnt", cnt_s, 2'd0);

      rst_n = 1'b1; rst2_n = 1'b1; s = 4'h0; r = 4'h0;
      step();
      chk("idle_q", q[0], 4'h5);
      chk("idle_chg", q_chg[0], 4'h0);

      // Set / reset / hold
      r = 4'hF; step();
      chk("rall_q", q[0], 4'h0);
      chk("rall_chg", q_chg[0], 4'h5);
      s = 4'h3; r = 4'h0; step();
      chk("set_q", q[0], 4'h3);
      chk("set_chg", q_chg[0], 4'h3);
      s = 4'h0; r = 4'h1; step();
      chk("reset_q", q[0], 4'h2);
      chk("reset_chg", q_chg[0], 4'h1);
      en = 1'b0; s = 4'hC; r = 4'hC; step();
      chk("dis_q", q[0], 4'h2);
      chk("dis_chg", q_chg[0], 4'h0);
      chk("dis_cf", cf[0], 4'h0);
      chk("dis_cnt", cnt[0], 8'd0);

      // MODE sweep from q=0101
      en = 1'b1; s = 4'h5; r = 4'hA; step();
      chk("pre_q", q[0], 4'h5);
      chk("pre_chg", q_chg[0], 4'h7);
      s = 4'hF; r = 4'hF; step();
      exp_q   = '{4'h5, 4'hF, 4'h0, 4'hA};
      exp_chg = '{4'h0, 4'hA, 4'h5, 4'hF};
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("sw1_q_m%0d", m), q[m], exp_q[m]);
         chk($sformatf("sw1_chg_m%0d", m), q_chg[m], exp_chg[m]);
         chk($sformatf("sw1_cf_m%0d", m), cf[m], 4'hF);
         chk($sformatf("sw1_cnt_m%0d", m), cnt[m], 8'd1);
      end
      step();
      exp_q   = '{4'h5, 4'hF, 4'h0, 4'h5};
      exp_chg = '{4'h0, 4'h0, 4'h0, 4'hF};
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("sw2_q_m%0d", m), q[m], exp_q[m]);
         chk($sformatf("sw2_chg_m%0d", m), q_chg[m], exp_chg[m]);
         chk($sformatf("sw2_cnt_m%0d", m), cnt[m], 8'd2);
      end

      // Sticky conflict behaviour
      s = 4'h0; r = 4'h0; conflict_clr = 4'hF; step();
      chk("stk_clr_cf", cf[0], 4'h0);
      chk("stk_clr_cnt", cnt[0], 8'd2);
      s = 4'h8; r = 4'h8; conflict_clr = 4'h8; step();
      chk("stk_same_cf", cf[0], 4'h8);
      chk("stk_same_cnt", cnt[0], 8'd3);
      chk("stk_tog_q", q[3], 4'hD);
      s = 4'h0; r = 4'h0; step();
      chk("stk_w1c_cf", cf[0], 4'h0);
      chk("stk_w1c_cnt", cnt[0], 8'd3);

      // clr priority
      conflict_clr = 4'h0; s = 4'h2; r = 4'h2; step();
      chk("pre_clr_cf", cf[0], 4'h2);
      chk("pre_clr_cnt", cnt[0], 8'd4);
      s = 4'hF; r = 4'h0; step();
      chk("pre_clr_q", q[0], 4'hF);
      chk("pre_clr_q3", q[3], 4'hF);
      clr = 1'b1; s = 4'hF; r = 4'hF; step();
      chk("clr_q", q[0], 4'h5);
      chk("clr_chg", q_chg[0], 4'hA);
      chk("clr_q3", q[3], 4'h5);
      chk("clr_cf", cf[0], 4'h2);
      chk("clr_cnt", cnt[0], 8'd4);
      clr = 1'b0; s = 4'hF; r = 4'h0; step();
      chk("post_clr_q", q[0], 4'hF);

      // Mid-operation reset with conflicting requests and clr asserted
      rst_n = 1'b0; clr = 1'b1; s = 4'hF; r = 4'hF; step();
      chk("mrst_q", q[0], 4'h5);
      chk("mrst_chg", q_chg[0], 4'h0);
      chk("mrst_cf", cf[0], 4'h0);
      chk("mrst_cnt", cnt[0], 8'd0);
      rst_n = 1'b1; clr = 1'b0; s = 4'h0; r = 4'h0;

      // Counter saturation with CNT_W=2
      sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      s2 = 4'h1; r2 = 4'h1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("sat_cnt_%0d", k), cnt_s, sat_tab[k]);
      end
      chk("sat_cf", cf_s, 4'h1);
      chk("sat_q", q_s, 4'h5);
      rst2_n = 1'b0; step();
      chk("sat_rst_cnt", cnt_s, 2'd0);
      chk("sat_rst_cf", cf_s, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
